bram_stream_reader: RTL
=======================

# bram_stream_reader

Read-side client for the dual-port block RAM: given a base address and a word count, it drives the RAM read port, absorbs the RAM's one-cycle read latency and streams the words out on a valid/ready interface at up to one word per cycle. It snoops the RAM write port so that a read colliding with a same-cycle write to the same address returns the newly written data. The RAM itself returns undefined data in that case. It sits between a dual-port RAM instance and any streaming consumer, such as a DMA, tile loader or trace dumper.

## Interface
- ADDR_WIDTH, 8, RAM address width; must equal the attached RAM's ADDR_WIDTH
- DATA_WIDTH, 32, RAM word width; must equal the attached RAM's DATA_WIDTH
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  begin a burst; sampled only when BUSY=0
- BASE  in  ADDR_WIDTH  first address of the burst
- LEN  in  ADDR_WIDTH+1  words in the burst, 0..2^ADDR_WIDTH
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse when a burst completes
- RAM_RE  out  1  RAM read enable
- RAM_RD_ADDR  out  ADDR_WIDTH  RAM read address
- RAM_DO  in  DATA_WIDTH  RAM read data, valid the cycle after RAM_RE
- RAM_WE, RAM_WR_ADDR, RAM_DI  in  1 / ADDR_WIDTH / DATA_WIDTH  snooped copy of the RAM write port
- OUT_VALID  out  1  OUT_DATA holds a word
- OUT_READY  in  1  consumer accepts the word
- OUT_DATA  out  DATA_WIDTH  streamed word, in ascending address order

## Operation
- The block has three states: IDLE, RUN and FLUSH.
- IDLE:
  - START=1 latches BASE into the address counter and LEN into the remaining counter.
  - If LEN≠0, go to RUN. If LEN=0, go to FLUSH without issuing any read.
  - BUSY=1 in every state except IDLE.
- RUN:
  - Issue a read (RAM_RE=1, RAM_RD_ADDR=address counter) when remaining>0 and occ+inflight−pop<2.
    - occ is the output-buffer occupancy, 0..2.
    - inflight is 1 if a read was issued last cycle.
    - pop is OUT_VALID&&OUT_READY.
  - Each issued read increments the address counter modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH−1 to 0) and decrements remaining.
  - Go to FLUSH when remaining reaches 0.
- FLUSH: wait until inflight=0 and occ=0, then pulse DONE for one cycle and return to IDLE. DONE and BUSY deassert in the same cycle.
- Output buffer:
  - 2-entry FIFO.
  - Returning read data is written into it the cycle after issue.
  - OUT_DATA is the head entry.
  - OUT_VALID=(occ>0).
  - The credit rule guarantees the buffer never overflows, so RAM_RE must never be issued without space.
- Collision forwarding:
  - Applies when RAM_RE && RAM_WE && RAM_WR_ADDR==RAM_RD_ADDR in a cycle.
  - Register a forward flag and RAM_DI. Next cycle, the buffer captures the registered RAM_DI instead of RAM_DO.
  - The result is write-first semantics.
  - No write in the cycle of the read means RAM_DO is used unmodified.
- START while BUSY=1 is ignored and is not queued.
- OUT_VALID, once asserted, holds with stable OUT_DATA until accepted.

## Timing
- Reset values, applied asynchronously on RST=1:
  - State IDLE, occ=0, inflight=0, forward flag 0.
  - BUSY=0, DONE=0, RAM_RE=0, RAM_RD_ADDR=0, OUT_VALID=0.
  - OUT_DATA=0.
- Reset mid-burst: the burst is abandoned, buffered and in-flight data are dropped, and no DONE is produced.
- RAM_RE and RAM_RD_ADDR are combinational from registered state only. They have no combinational path from OUT_READY, except through pop in the credit term.
- Burst timeline, with START sampled at edge t:
  - BUSY=1 from cycle t+1.
  - First RAM_RE in cycle t+1.
  - First OUT_VALID in cycle t+3.
- Throughput: with OUT_READY held at 1, one word per cycle. A burst of N words shows OUT_VALID continuously for cycles t+3..t+N+2, and DONE in cycle t+N+3.
- LEN=0: DONE in cycle t+2, with no RAM_RE.
- Backpressure: with OUT_READY=0, at most 2 reads are outstanding beyond the consumer. RAM_RE stays 0 until a pop frees a credit.

## Test plan
- Fill RAM[i]=i+0x100, then BASE=4, LEN=8, OUT_READY=1 → words 0x104..0x10B, one per cycle from t+3, DONE at t+11, 8 RAM_RE pulses.
- BASE=0xFE, LEN=4, ADDR_WIDTH=8 → RAM_RD_ADDR sequence FE, FF, 00, 01; data matches RAM contents.
- LEN=8 with OUT_READY toggled randomly, including 20 consecutive low cycles → all 8 words arrive in order with none duplicated or lost, RAM_RE stays 0 while the buffer is full, and OUT_DATA is stable while stalled.
- Write RAM_DI=0xDEAD to address 6 in the same cycle the block reads address 6 (RAM holds 0x106) → OUT_DATA for that slot is 0xDEAD.
- LEN=0 → DONE one cycle after BUSY rises, no RAM_RE. START pulses during a LEN=5 burst → ignored, exactly 5 words and a single DONE.
- RST asserted mid-burst with 2 words buffered → outputs go to reset values immediately. A new START with BASE=0, LEN=2 afterwards delivers exactly 2 correct words.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a burst of words out of a dual-port block RAM.
// Drives the RAM read port, absorbs the one-cycle read latency through a
// 2-entry output buffer, and forwards same-cycle write data on an address
// collision so the stream observes write-first behaviour.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for START; BUSY=0
// RUN     | issuing reads while words remain and the buffer has credit
// FLUSH   | all reads issued; drain in-flight and buffered words, pulse DONE
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE,
  input  logic [ADDR_WIDTH:0]   LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  RAM_RE,
  output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_DO,
  input  logic                  RAM_WE,
  input  logic [ADDR_WIDTH-1:0] RAM_WR_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_DI,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            credit_use;

  assign OUT_VALID   = (occ_q != 2'd0);
  assign OUT_DATA    = mem_q[rd_ptr_q];
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = done_q;
  assign RAM_RD_ADDR = addr_q;
  assign pop         = OUT_VALID && OUT_READY;
  assign push        = inflight_q;

  // Slots claimed by buffered plus in-flight words, after this cycle's pop.
  assign credit_use = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign RAM_RE     = (state_q == S_RUN) && (rem_q != '0) && (credit_use < 3'd2);

  // Output buffer: capture returning (or forwarded) data, advance head on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = fwd_q ? fwd_data_q : RAM_DO;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Sequencing FSM, address/remaining counters and collision snoop.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    inflight_d = RAM_RE;
    fwd_d      = RAM_RE && RAM_WE && (RAM_WR_ADDR == RAM_RD_ADDR);
    fwd_data_d = RAM_DI;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = BASE;
          rem_d   = LEN;
          state_d = (LEN != '0) ? S_RUN : S_FLUSH;
        end
      end
      S_RUN: begin
        if (RAM_RE) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // DONE is registered one cycle ahead of the drained condition so it
        // lands on the first empty cycle; BUSY drops together with it.
        if (done_q) begin
          state_d = S_IDLE;
        end else if (!inflight_q && (occ_d == 2'd0)) begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any burst and drops buffered data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      mem_q      <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      done_q     <= done_d;
    end
  end

endmodule
